div_seq: RTL and testbench

Iterative 32-bit divide sequencer for the EX stage. Accepts a signed or unsigned divide request from EX and runs a radix-2 restoring divide over 32 cycles. Returns {remainder, quotient} for the HI/LO write path. Holds the pipeline through a stall request while busy.

---
 rtl/div_seq_pkg.sv | 21 ++
 rtl/div_seq.sv | 133 +++++++++++++
 tb/tb_div_seq.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// Pipeline defines shared by EX decode and the iterative divider:
// divider state encodings, iteration count, and the DIV/DIVU aluop codes.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic [5:0] DIV_ITER    = 6'd32;
  localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

  // Magnitude of an operand; negative values only fold when the divide is signed.
  function automatic logic [31:0] div_mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_seq.sv
// Radix-2 restoring divider for EX: 32 iterations on operand magnitudes,
// sign fix at the end, returns {remainder, quotient} for the HI/LO write.
module div_seq
  import div_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        annul,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  output logic [63:0] result,
  output logic        ready,
  output logic        stallreq_div
);

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;
  logic        sgn_q, sgn_d;
  logic        neg1_q, neg1_d;
  logic        neg2_q, neg2_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [32:0] diff;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // Partial remainder sits in dividend[63:32] with the next dividend bit shifted in.
  assign diff    = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};
  assign quo_fix = (sgn_q && (neg1_q ^ neg2_q)) ? (~dividend_q[31:0] + 32'd1) : dividend_q[31:0];
  assign rem_fix = (sgn_q && neg1_q) ? (~dividend_q[64:33] + 32'd1) : dividend_q[64:33];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    sgn_d      = sgn_q;
    neg1_d     = neg1_q;
    neg2_d     = neg2_q;
    result_d   = result_q;
    ready_d    = ready_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (start && !annul) begin
          if (opdata2 == 32'd0) begin
            state_d = DIV_BYZERO;
          end else begin
            state_d    = DIV_ON;
            cnt_d      = 6'd0;
            dividend_d = {32'd0, div_mag(opdata1, signed_div), 1'b0};
            divisor_d  = div_mag(opdata2, signed_div);
            sgn_d      = signed_div;
            neg1_d     = opdata1[31];
            neg2_d     = opdata2[31];
          end
        end
      end
      DIV_BYZERO: begin
        if (annul) begin
          state_d  = DIV_IDLE;
          result_d = 64'd0;
          ready_d  = 1'b0;
          cnt_d    = 6'd0;
        end else begin
          state_d  = DIV_END;
          result_d = 64'd0;
          ready_d  = 1'b1;
        end
      end
      DIV_ON: begin
        if (annul) begin
          state_d  = DIV_IDLE;
          result_d = 64'd0;
          ready_d  = 1'b0;
          cnt_d    = 6'd0;
        end else if (cnt_q != DIV_ITER) begin
          if (diff[32]) dividend_d = {dividend_q[63:0], 1'b0};
          else          dividend_d = {diff[31:0], dividend_q[31:0], 1'b1};
          cnt_d = cnt_q + 6'd1;
        end else begin
          state_d  = DIV_END;
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
        end
      end
      DIV_END: begin
        if (annul) begin
          state_d = DIV_IDLE;
          ready_d = 1'b0;
        end else if (!start) begin
          state_d  = DIV_IDLE;
          result_d = 64'd0;
          ready_d  = 1'b0;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= 6'd0;
      dividend_q <= 65'd0;
      divisor_q  <= 32'd0;
      sgn_q      <= 1'b0;
      neg1_q     <= 1'b0;
      neg2_q     <= 1'b0;
      result_q   <= 64'd0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      sgn_q      <= sgn_d;
      neg1_q     <= neg1_d;
      neg2_q     <= neg2_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result       = result_q;
  assign ready        = ready_q;
  assign stallreq_div = start & ~ready_q & ~annul;

endmodule

// File: tb/tb_div_seq.sv
// Directed and randomized checks of div_seq against a plain-arithmetic divide model.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        annul;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;
  logic        stallreq_div;

  int errors = 0;
  int checks = 0;

  div_seq dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .annul        (annul),
    .signed_div   (signed_div),
    .opdata1      (opdata1),
    .opdata2      (opdata2),
    .result       (result),
    .ready        (ready),
    .stallreq_div (stallreq_div)
  );

  always #5 clk = ~clk;

  // Reference: truncating division on 64-bit integers; zero divisor yields 0.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint la, lb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
    end else begin
      la = longint'({32'd0, a});
      lb = longint'({32'd0, b});
    end
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Raise start and let n edges pass (first edge is the acceptance edge).
  task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b, input logic s, input int n);
    @(negedge clk);
    opdata1 = a; opdata2 = b; signed_div = s; start = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
    logic [63:0] exp;
    int          edges;
    bit          got;
    bit          stall_ok;
    exp = model(a, b, s);
    @(negedge clk);
    opdata1 = a; opdata2 = b; signed_div = s; start = 1'b1;
    #1 stall_ok = (stallreq_div === 1'b1);
    edges = 0;
    got   = 0;
    while (!got && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) begin
        opdata1 = $urandom; opdata2 = $urandom; signed_div = ~s;
      end
      if (ready === 1'b1) got = 1;
      else if (stallreq_div !== 1'b1) stall_ok = 0;
    end
    check({tag, " latency"}, 64'(edges), (b == 32'd0) ? 64'd2 : 64'd34);
    check({tag, " result"}, result, exp);
    check({tag, " stall while busy"}, {63'd0, stall_ok}, 64'd1);
    check({tag, " stall in ready cycle"}, {63'd0, stallreq_div}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, " release"}, {ready, result[62:0]} | {63'd0, result[63]}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    reset_n = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    opdata1 = 32'd0; opdata2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset result", result, 64'd0);
    check("reset ready/stall", {62'd0, ready, stallreq_div}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    do_div(32'd100, 32'd7, 1'b0, "divu 100/7");
    check("divu 100/7 const", model(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
    do_div(32'hFFFFFFF9, 32'h2, 1'b1, "div -7/2");
    do_div(32'h7, 32'hFFFFFFFE, 1'b1, "div 7/-2");
    do_div(32'hFFFFFFF9, 32'h2, 1'b0, "divu big/2");
    do_div(32'd5, 32'd0, 1'b0, "div by zero");
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, "div overflow");

    // Abort at iteration 10, then an immediate new divide.
    start_and_wait(32'd1000, 32'd7, 1'b0, 11);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk); #1;
    check("annul ready", {63'd0, ready}, 64'd0);
    check("annul result", result, 64'd0);
    annul = 1'b0;
    do_div(32'd9, 32'd3, 1'b0, "after annul 9/3");

    // Reset during iteration 20.
    start_and_wait(32'd123456, 32'd77, 1'b1, 21);
    @(negedge clk);
    reset_n = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("midreset outputs", {ready, stallreq_div, result[61:0]} | {62'd0, result[63:62]}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    do_div(32'd50, 32'd6, 1'b0, "after reset 50/6");

    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) rb = $urandom_range(0, 1000);
      else                           rb = $urandom;
      if ($urandom_range(0, 1) == 1 && rs) rb = -rb;
      if (!rs) rb = rb & 32'h7FFFFFFF;
      do_div(ra, rb, rs, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
